fru_cfg_loader: RTL and testbench

Serial configuration loader directly upstream of the FRU. It deserializes the `BitStreamSerialIn`/`BitStreamValid` stream into a shadow register and checks a CRC-8 over the payload. Only when a complete, CRC-clean frame has arrived does it commit the shadow atomically to `CfgRegFru`, which drives the FRU's filter-constant and PLA configuration. Corrupt or truncated frames never disturb the live configuration.

---
 rtl/fru_pkg.sv | 18 +
 rtl/fru_crc8_serial.sv | 23 ++
 rtl/fru_cfg_loader.sv | 138 +++++++++++++
 tb/tb_fru_cfg_loader.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fru_pkg.sv
// rtl/fru_pkg.sv - shared types and constants for the FRU configuration path
package fru_pkg;

  typedef enum logic [1:0] {HUNT, LOAD, CHECK} cfg_ld_state_t;

  localparam logic [7:0] CRC8_POLY         = 8'h07;
  localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

  // M*F filter coefficients of C+3 bits each, plus one PLA enable per S/SEGMENT_SIZE segment.
  function automatic int unsigned fru_cfg_width(input int unsigned m, input int unsigned f,
                                                input int unsigned c, input int unsigned s,
                                                input int unsigned segment_size);
    return m * f * (c + 3) + (s + segment_size - 1) / segment_size;
  endfunction

  localparam int unsigned FRU_CFG_WIDTH = fru_cfg_width(6, 12, 5, 20, 3);

endpackage

// File: rtl/fru_crc8_serial.sv
// rtl/fru_crc8_serial.sv - bit-serial CRC-8 (init 0) over the configuration payload
module fru_crc8_serial
  import fru_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[6:0], 1'b0} ^ ((crc[7] ^ bit_in) ? CRC8_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/fru_cfg_loader.sv
// rtl/fru_cfg_loader.sv - serial frame loader; commits a CRC-clean shadow to the live FRU config
module fru_cfg_loader
  import fru_pkg::*;
#(
  parameter int unsigned CFG_WIDTH = FRU_CFG_WIDTH,
  parameter logic [7:0]  SYNC_WORD = DEFAULT_SYNC_WORD,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 BitStreamSerialIn,
  input  logic                 BitStreamValid,
  output logic [CFG_WIDTH-1:0] CfgRegFru,
  output logic                 CfgCommit,
  output logic                 CfgError,
  output logic                 Busy
);

  localparam int unsigned      CNT_W     = $clog2(CFG_WIDTH);
  localparam int unsigned      GAP_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CFG_WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_MAX   = GAP_W'(TIMEOUT);

  cfg_ld_state_t        state_q, state_d;
  logic [7:0]           window_q, window_d, rx_crc_q, rx_crc_d, crc;
  logic [7:0]           win_shift, rx_shift;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           crc_cnt_q, crc_cnt_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [CFG_WIDTH-1:0] shadow_q, shadow_d, cfg_d;
  logic                 commit_d, error_d, crc_clr, crc_en;

  assign win_shift = {window_q[6:0], BitStreamSerialIn};
  assign rx_shift  = {rx_crc_q[6:0], BitStreamSerialIn};
  assign Busy      = (state_q != HUNT);

  fru_crc8_serial u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (BitStreamSerialIn),
    .crc    (crc)
  );

  always_comb begin
    state_d   = state_q;
    window_d  = window_q;
    rx_crc_d  = rx_crc_q;
    cnt_d     = cnt_q;
    crc_cnt_d = crc_cnt_q;
    gap_d     = gap_q;
    shadow_d  = shadow_q;
    cfg_d     = CfgRegFru;
    commit_d  = 1'b0;
    error_d   = 1'b0;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;

    case (state_q)
      HUNT: if (BitStreamValid) begin
        window_d = win_shift;
        if (win_shift == SYNC_WORD) begin
          state_d  = LOAD;
          window_d = '0;
          cnt_d    = '0;
          gap_d    = '0;
          crc_clr  = 1'b1;
        end
      end
      LOAD: if (BitStreamValid) begin
        shadow_d = {shadow_q[CFG_WIDTH-2:0], BitStreamSerialIn};
        crc_en   = 1'b1;
        gap_d    = '0;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d   = CHECK;
          crc_cnt_d = '0;
        end
      end
      CHECK: if (BitStreamValid) begin
        rx_crc_d  = rx_shift;
        crc_cnt_d = crc_cnt_q + 1'b1;
        gap_d     = '0;
        if (crc_cnt_q == 3'd7) begin
          if (rx_shift == crc) begin
            cfg_d    = shadow_q;
            commit_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          state_d  = HUNT;
          window_d = '0;
        end
      end
      default: state_d = HUNT;
    endcase

    // A stalled frame is abandoned; the live configuration is left untouched.
    if (state_q != HUNT && !BitStreamValid) begin
      if (gap_q != GAP_MAX) gap_d = gap_q + 1'b1;
      if (gap_q == GAP_LIMIT) begin
        error_d  = 1'b1;
        state_d  = HUNT;
        window_d = '0;
        shadow_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= HUNT;
      window_q  <= '0;
      rx_crc_q  <= '0;
      cnt_q     <= '0;
      crc_cnt_q <= '0;
      gap_q     <= '0;
      shadow_q  <= '0;
      CfgRegFru <= '0;
      CfgCommit <= 1'b0;
      CfgError  <= 1'b0;
    end else begin
      state_q   <= state_d;
      window_q  <= window_d;
      rx_crc_q  <= rx_crc_d;
      cnt_q     <= cnt_d;
      crc_cnt_q <= crc_cnt_d;
      gap_q     <= gap_d;
      shadow_q  <= shadow_d;
      CfgRegFru <= cfg_d;
      CfgCommit <= commit_d;
      CfgError  <= error_d;
    end
  end

endmodule

// File: tb/tb_fru_cfg_loader.sv
// tb/tb_fru_cfg_loader.sv - directed self-checking bench for fru_cfg_loader
module tb_fru_cfg_loader;

  localparam int         W    = 583;
  localparam int         TO   = 1024;
  localparam logic [7:0] SYNC = 8'hA5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         din = 1'b0;
  logic         valid = 1'b0;
  logic [W-1:0] cfg;
  logic         commit, error, busy;

  int n_cmp = 0, n_fail = 0, n_commit = 0, n_error = 0;
  logic [W-1:0] p_alt, p_thirds, p_sync;

  fru_cfg_loader dut (
    .clk               (clk),
    .rst               (rst),
    .BitStreamSerialIn (din),
    .BitStreamValid    (valid),
    .CfgRegFru         (cfg),
    .CfgCommit         (commit),
    .CfgError          (error),
    .Busy              (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if (commit) n_commit++;
      if (error) n_error++;
    end
  end

  function automatic logic [7:0] crc8(input logic [W-1:0] p);
    logic [7:0] c = 8'h00;
    for (int i = W - 1; i >= 0; i--) c = {c[6:0], 1'b0} ^ ((c[7] ^ p[i]) ? 8'h07 : 8'h00);
    return c;
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk); valid = 1'b1; din = b;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); valid = 1'b0; din = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_payload(input logic [W-1:0] p, input int from, input int upto, input int gap_max);
    for (int i = from; i < upto; i++) begin
      if (gap_max > 0 && i % 16 == 0) idle(int'($urandom_range(1, gap_max)));
      send_bit(p[W-1-i]);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] p, input logic [7:0] crc_xor, input int gap_max);
    send_byte(SYNC);
    send_payload(p, 0, W, gap_max);
    if (gap_max > 0) idle(int'($urandom_range(1, gap_max)));
    send_byte(crc8(p) ^ crc_xor);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (cfg !== '0) begin n_fail++; $display("FAIL reset_cfg: got %h want 0", cfg); end
    n_cmp++; if (commit !== 1'b0) begin n_fail++; $display("FAIL reset_commit: got %b want 0", commit); end
    n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", error); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk); rst = 1'b1;
    idle(2);
    n_cmp++; if (busy !== 1'b0 || cfg !== '0) begin n_fail++; $display("FAIL post_reset_idle: busy %b cfg %h want 0/0", busy, cfg); end
  endtask

  task automatic test_corrupt_crc();
    int c0 = n_commit, e0 = n_error;
    send_frame(p_alt, 8'h01, 0);
    n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL corrupt_error: got %b want 1", error); end
    n_cmp++; if (commit !== 1'b0) begin n_fail++; $display("FAIL corrupt_commit: got %b want 0", commit); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL corrupt_busy: got %b want 0", busy); end
    n_cmp++; if (cfg !== '0) begin n_fail++; $display("FAIL corrupt_cfg: got %h want 0", cfg); end
    idle(1);
    n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL corrupt_error_pulse: got %b want 0", error); end
    n_cmp++; if (n_error != e0 + 1 || n_commit != c0) begin n_fail++; $display("FAIL corrupt_counts: errors %0d commits %0d want %0d %0d", n_error - e0, n_commit - c0, 1, 0); end
  endtask

  task automatic test_good_frame();
    int c0 = n_commit, e0 = n_error;
    send_frame(p_alt, 8'h00, 0);
    n_cmp++; if (commit !== 1'b1) begin n_fail++; $display("FAIL good_commit: got %b want 1", commit); end
    n_cmp++; if (cfg !== p_alt) begin n_fail++; $display("FAIL good_cfg: got %h want %h", cfg, p_alt); end
    n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL good_error: got %b want 0", error); end
    idle(1);
    n_cmp++; if (commit !== 1'b0) begin n_fail++; $display("FAIL good_commit_pulse: got %b want 0", commit); end
    n_cmp++; if (n_commit != c0 + 1 || n_error != e0) begin n_fail++; $display("FAIL good_counts: commits %0d errors %0d want 1 0", n_commit - c0, n_error - e0); end
  endtask

  task automatic test_noise_sync();
    logic [7:0] c = crc8(p_thirds);
    send_byte(8'h5A);
    send_byte(8'hFF);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL noise_false_lock: busy %b want 0", busy); end
    for (int i = 7; i >= 1; i--) send_bit(SYNC[i]);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sync_early_lock: busy %b want 0", busy); end
    send_bit(SYNC[0]);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sync_lock: busy %b want 1", busy); end
    send_payload(p_thirds, 0, W, 0);
    for (int i = 7; i >= 1; i--) send_bit(c[i]);
    n_cmp++; if (commit !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL noise_early_commit: commit %b busy %b want 0 1", commit, busy); end
    send_bit(c[0]);
    n_cmp++; if (commit !== 1'b1) begin n_fail++; $display("FAIL noise_commit: got %b want 1", commit); end
    n_cmp++; if (cfg !== p_thirds) begin n_fail++; $display("FAIL noise_cfg: got %h want %h", cfg, p_thirds); end
    idle(1);
  endtask

  task automatic test_valid_gaps();
    int c0 = n_commit, e0 = n_error;
    send_frame(p_sync, 8'h00, 100);
    n_cmp++; if (commit !== 1'b1) begin n_fail++; $display("FAIL gaps_commit: got %b want 1", commit); end
    n_cmp++; if (cfg !== p_sync) begin n_fail++; $display("FAIL gaps_cfg: got %h want %h", cfg, p_sync); end
    idle(1);
    n_cmp++; if (n_commit != c0 + 1 || n_error != e0) begin n_fail++; $display("FAIL gaps_counts: commits %0d errors %0d want 1 0", n_commit - c0, n_error - e0); end
  endtask

  task automatic test_timeout();
    int e0 = n_error;
    send_byte(SYNC);
    send_payload(p_alt, 0, 100, 0);
    idle(TO - 1);
    n_cmp++; if (error !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL gap_below_limit: error %b busy %b want 0 1", error, busy); end
    send_payload(p_alt, 100, 300, 0);
    idle(TO - 1);
    n_cmp++; if (error !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL gap_not_cleared: error %b busy %b want 0 1", error, busy); end
    idle(1);
    n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL timeout_error: got %b want 1", error); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b want 0", busy); end
    n_cmp++; if (cfg !== p_sync) begin n_fail++; $display("FAIL timeout_cfg: got %h want %h", cfg, p_sync); end
    idle(1);
    n_cmp++; if (error !== 1'b0 || n_error != e0 + 1) begin n_fail++; $display("FAIL timeout_pulse: error %b count %0d want 0 1", error, n_error - e0); end
  endtask

  task automatic test_reset_mid_load();
    send_frame(p_thirds, 8'h00, 0);
    n_cmp++; if (cfg !== p_thirds) begin n_fail++; $display("FAIL prior_cfg: got %h want %h", cfg, p_thirds); end
    send_byte(SYNC);
    send_payload(p_alt, 0, 200, 0);
    @(negedge clk); rst = 1'b0; valid = 1'b0;
    #1;
    n_cmp++; if (cfg !== '0) begin n_fail++; $display("FAIL midreset_cfg: got %h want 0", cfg); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
    @(negedge clk); rst = 1'b1;
    send_frame(p_alt, 8'h00, 0);
    n_cmp++; if (commit !== 1'b1 || cfg !== p_alt) begin n_fail++; $display("FAIL after_reset_frame: commit %b cfg %h want 1 %h", commit, cfg, p_alt); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    int c0 = n_commit, e0 = n_error;
    send_frame(p_thirds, 8'h00, 0);
    n_cmp++; if (commit !== 1'b1 || cfg !== p_thirds) begin n_fail++; $display("FAIL b2b_first: commit %b cfg %h want 1 %h", commit, cfg, p_thirds); end
    send_frame(p_sync, 8'h00, 0);
    n_cmp++; if (commit !== 1'b1 || cfg !== p_sync) begin n_fail++; $display("FAIL b2b_second: commit %b cfg %h want 1 %h", commit, cfg, p_sync); end
    idle(1);
    n_cmp++; if (n_commit != c0 + 2 || n_error != e0) begin n_fail++; $display("FAIL b2b_counts: commits %0d errors %0d want 2 0", n_commit - c0, n_error - e0); end
  endtask

  initial begin
    for (int i = 0; i < W; i++) begin
      p_alt[i]        = (i % 2 == 0);
      p_thirds[i]     = (i % 3 == 0);
      p_sync[W-1-i]   = SYNC[7 - (i % 8)];
    end
    test_reset();
    test_corrupt_crc();
    test_good_frame();
    test_noise_sync();
    test_valid_gaps();
    test_timeout();
    test_reset_mid_load();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
